// File: rtl/tt_ldb_drain_sequencer.sv
// Load-data-buffer drain sequencer for the vector load path.
// Runs one drain job at a time. Each job reads a run of load-queue entries
// in order and writes their data into consecutive LDB slots. Every write
// frees its LQ entry and reports the completed slot back to the scoreboard.
// LQ read responses pass through a small FIFO. Reads are limited by credit,
// so that FIFO can never overflow.
// A flush aborts the job. Responses for reads that were already issued are
// counted and dropped when they come back later.
module tt_ldb_drain_sequencer #(
    parameter int LQ_DEPTH       = 8,
    parameter int LDB_DEPTH      = 8,
    parameter int DATA_W         = 512,
    parameter int RSP_FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_drain_req_valid,
    input  logic [3:0]                   i_drain_req_count,
    input  logic [$clog2(LQ_DEPTH)-1:0]  i_drain_req_lqid,
    input  logic [$clog2(LDB_DEPTH)-1:0] i_drain_req_ldb,
    output logic                         o_draining,
    output logic                         o_lq_rd_valid,
    output logic [$clog2(LQ_DEPTH)-1:0]  o_lq_rd_idx,
    input  logic                         i_lq_rd_ready,
    input  logic                         i_lq_rsp_valid,
    input  logic [DATA_W-1:0]            i_lq_rsp_data,
    output logic                         o_ldb_wr_valid,
    output logic [$clog2(LDB_DEPTH)-1:0] o_ldb_wr_idx,
    output logic [DATA_W-1:0]            o_ldb_wr_data,
    input  logic                         i_ldb_wr_ready,
    output logic                         o_lq_free_valid,
    output logic [$clog2(LQ_DEPTH)-1:0]  o_lq_free_idx,
    output logic                         o_drain_complete_valid,
    output logic [$clog2(LDB_DEPTH)-1:0] o_drain_complete_ldb_idx,
    input  logic                         i_flush
);

    localparam int LQ_W  = $clog2(LQ_DEPTH);
    localparam int LDB_W = $clog2(LDB_DEPTH);
    localparam int PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(RSP_FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN_WAIT
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               job_accept;

    logic [3:0]         job_count_reg;
    logic [LQ_W-1:0]    job_lqid_reg;
    logic [LDB_W-1:0]   job_ldb_reg;
    logic [3:0]         rd_issued_reg;
    logic [3:0]         rd_issued_next;
    logic [3:0]         wr_done_reg;
    logic [3:0]         wr_done_next;
    logic [3:0]         outstanding_reg;
    logic [3:0]         drop_cnt_reg;
    logic [3:0]         drop_cnt_next;

    logic [DATA_W-1:0]  fifo_mem [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0]   fifo_rd_ptr_reg;
    logic [PTR_W-1:0]   fifo_wr_ptr_reg;
    logic [OCC_W-1:0]   fifo_occ_reg;

    logic               busy;
    logic               rd_valid;
    logic               rd_hs;
    logic               rsp_drop;
    logic               rsp_ours;
    logic               fifo_push;
    logic               fifo_pop;
    logic               wr_valid;
    logic               wr_hs;
    logic [4:0]         credit_used;
    logic [LQ_W-1:0]    rd_idx;
    logic [LQ_W-1:0]    free_idx;
    logic [LDB_W-1:0]   wr_idx;

    // Advance a FIFO pointer. The FIFO depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshakes, credit check and wrapped indices.
    // A read is issued only if its response is sure to have room in the FIFO.
    // Responses are dropped while there are still aborted reads to discard.
    always_comb begin
        busy           = (state_reg != ST_IDLE);
        credit_used    = 5'(outstanding_reg) + 5'(fifo_occ_reg);
        rd_valid       = (state_reg == ST_RUN) && (rd_issued_reg < job_count_reg)
                         && (credit_used < 5'(RSP_FIFO_DEPTH));
        rd_hs          = rd_valid && i_lq_rd_ready;
        rsp_drop       = i_lq_rsp_valid && (drop_cnt_reg != 4'd0);
        rsp_ours       = i_lq_rsp_valid && (drop_cnt_reg == 4'd0) && (outstanding_reg != 4'd0);
        fifo_push      = rsp_ours;
        wr_valid       = (fifo_occ_reg != '0);
        wr_hs          = wr_valid && i_ldb_wr_ready;
        fifo_pop       = wr_hs;
        rd_issued_next = rd_issued_reg + 4'(rd_hs);
        wr_done_next   = wr_done_reg + 4'(wr_hs);
        rd_idx         = job_lqid_reg + LQ_W'(rd_issued_reg);
        free_idx       = job_lqid_reg + LQ_W'(wr_done_reg);
        wr_idx         = job_ldb_reg + LDB_W'(wr_done_reg);
        drop_cnt_next  = drop_cnt_reg - 4'(rsp_drop);
        if (i_flush) begin
            drop_cnt_next = drop_cnt_next + outstanding_reg + 4'(rd_hs) - 4'(rsp_ours);
        end
    end

    // Job sequencing. The job ends in the cycle its last write is accepted.
    // A zero-count job therefore spends exactly one cycle busy. Flush wins
    // over everything, including a request arriving in the same cycle.
    always_comb begin
        state_next = state_reg;
        job_accept = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_drain_req_valid) begin
                    job_accept = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN_WAIT: begin
                if (rd_issued_next == job_count_reg) begin
                    state_next = (wr_done_next == job_count_reg) ? ST_IDLE : ST_DRAIN_WAIT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (i_flush) begin
            state_next = ST_IDLE;
            job_accept = 1'b0;
        end
    end

    // State register, latched job, and progress and drop counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            job_count_reg   <= '0;
            job_lqid_reg    <= '0;
            job_ldb_reg     <= '0;
            rd_issued_reg   <= '0;
            wr_done_reg     <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (job_accept) begin
                job_count_reg <= i_drain_req_count;
                job_lqid_reg  <= i_drain_req_lqid;
                job_ldb_reg   <= i_drain_req_ldb;
                rd_issued_reg <= '0;
                wr_done_reg   <= '0;
            end else begin
                rd_issued_reg <= rd_issued_next;
                wr_done_reg   <= wr_done_next;
            end
            outstanding_reg <= i_flush ? 4'd0 : outstanding_reg + 4'(rd_hs) - 4'(rsp_ours);
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    // Response FIFO control. A flush empties it together with the job.
    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            fifo_rd_ptr_reg <= '0;
            fifo_wr_ptr_reg <= '0;
            fifo_occ_reg    <= '0;
        end else begin
            assert (!(fifo_push && !fifo_pop && (fifo_occ_reg == OCC_W'(RSP_FIFO_DEPTH))));
            if (fifo_push) fifo_wr_ptr_reg <= ptr_inc(fifo_wr_ptr_reg);
            if (fifo_pop)  fifo_rd_ptr_reg <= ptr_inc(fifo_rd_ptr_reg);
            fifo_occ_reg <= fifo_occ_reg + OCC_W'(fifo_push) - OCC_W'(fifo_pop);
        end
    end

    // FIFO storage. It is not reset, because every read of it is gated by occupancy.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr_reg] <= i_lq_rsp_data;
    end

    // Output drive. Index and data buses read zero whenever their valid is low.
    always_comb begin
        o_draining               = busy;
        o_lq_rd_valid            = rd_valid;
        o_lq_rd_idx              = rd_valid ? rd_idx : '0;
        o_ldb_wr_valid           = wr_valid;
        o_ldb_wr_idx             = wr_valid ? wr_idx : '0;
        o_ldb_wr_data            = wr_valid ? fifo_mem[fifo_rd_ptr_reg] : '0;
        o_lq_free_valid          = wr_hs;
        o_lq_free_idx            = wr_hs ? free_idx : '0;
        o_drain_complete_valid   = wr_hs;
        o_drain_complete_ldb_idx = wr_hs ? wr_idx : '0;
    end

endmodule

// File: tb/tb_tt_ldb_drain_sequencer.sv
// Self-checking bench for tt_ldb_drain_sequencer.
// The reference is job-level. The n-th read of a job must address lqid+n.
// The n-th write must carry the data returned for the n-th read, to slot
// ldb+n, and free LQ entry lqid+n. Responses to reads made before a flush
// or before a new job belong to an older job and must never be written.
module tb_tt_ldb_drain_sequencer;

    localparam int DW = 512;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_drain_req_valid;
    logic [3:0]    i_drain_req_count;
    logic [2:0]    i_drain_req_lqid;
    logic [2:0]    i_drain_req_ldb;
    logic          o_draining;
    logic          o_lq_rd_valid;
    logic [2:0]    o_lq_rd_idx;
    logic          i_lq_rd_ready;
    logic          i_lq_rsp_valid;
    logic [DW-1:0] i_lq_rsp_data;
    logic          o_ldb_wr_valid;
    logic [2:0]    o_ldb_wr_idx;
    logic [DW-1:0] o_ldb_wr_data;
    logic          i_ldb_wr_ready;
    logic          o_lq_free_valid;
    logic [2:0]    o_lq_free_idx;
    logic          o_drain_complete_valid;
    logic [2:0]    o_drain_complete_ldb_idx;
    logic          i_flush;

    always #5 clk = ~clk;

    tt_ldb_drain_sequencer #(
        .LQ_DEPTH(8), .LDB_DEPTH(8), .DATA_W(DW), .RSP_FIFO_DEPTH(RD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_drain_req_valid(i_drain_req_valid), .i_drain_req_count(i_drain_req_count),
        .i_drain_req_lqid(i_drain_req_lqid), .i_drain_req_ldb(i_drain_req_ldb),
        .o_draining(o_draining),
        .o_lq_rd_valid(o_lq_rd_valid), .o_lq_rd_idx(o_lq_rd_idx), .i_lq_rd_ready(i_lq_rd_ready),
        .i_lq_rsp_valid(i_lq_rsp_valid), .i_lq_rsp_data(i_lq_rsp_data),
        .o_ldb_wr_valid(o_ldb_wr_valid), .o_ldb_wr_idx(o_ldb_wr_idx),
        .o_ldb_wr_data(o_ldb_wr_data), .i_ldb_wr_ready(i_ldb_wr_ready),
        .o_lq_free_valid(o_lq_free_valid), .o_lq_free_idx(o_lq_free_idx),
        .o_drain_complete_valid(o_drain_complete_valid),
        .o_drain_complete_ldb_idx(o_drain_complete_ldb_idx),
        .i_flush(i_flush)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Environment knobs
    int rd_pct = 100;
    int wr_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    bit wr_block = 1'b0;

    typedef struct { logic [DW-1:0] d; int tag; int due; } rsp_t;
    typedef struct { logic [DW-1:0] d; int arr; } arr_t;
    rsp_t pipe[$];
    arr_t arrived[$];
    int   cur_tag;

    // Job-level reference state
    bit exp_busy = 1'b0;
    int j_count, j_lqid, j_ldb, m_rd, m_wr;
    int serial = 0;
    int n_accept = 0;
    bit prev_rst = 1'b0;
    bit prev_wr_stall = 1'b0;
    bit prev_rd_stall = 1'b0;
    logic [2:0]    prev_wr_idx, prev_rd_idx;
    logic [DW-1:0] prev_wr_data;
    int rd_log[$];
    int wr_log[$];

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Runs at each negedge. It sees the values the next posedge will sample.
    function automatic void monitor();
        bit wr_hs;
        bit next_busy;
        if (prev_rst) begin
            chk("rst_outputs_zero", 512'(|{o_draining, o_lq_rd_valid, o_lq_rd_idx, o_ldb_wr_valid,
                o_ldb_wr_idx, o_ldb_wr_data, o_lq_free_valid, o_lq_free_idx,
                o_drain_complete_valid, o_drain_complete_ldb_idx}), 0);
        end
        if (!reset_n) begin
            prev_rst = 1'b1;
            exp_busy = 1'b0;
            prev_wr_stall = 1'b0;
            prev_rd_stall = 1'b0;
            arrived.delete();
            pipe.delete();
            serial++;
            return;
        end
        prev_rst = 1'b0;

        chk("draining", o_draining, exp_busy);
        wr_hs = o_ldb_wr_valid && i_ldb_wr_ready;
        chk("free_valid", o_lq_free_valid, wr_hs);
        chk("complete_valid", o_drain_complete_valid, wr_hs);

        if (prev_wr_stall) begin
            chk("wr_hold_valid", o_ldb_wr_valid, 1);
            chk("wr_hold_idx", o_ldb_wr_idx, prev_wr_idx);
            chk("wr_hold_data", o_ldb_wr_data, prev_wr_data);
        end
        if (prev_rd_stall) begin
            chk("rd_hold_valid", o_lq_rd_valid, 1);
            chk("rd_hold_idx", o_lq_rd_idx, prev_rd_idx);
        end

        if (o_lq_rd_valid) begin
            chk("rd_allowed", 512'(exp_busy && (m_rd < j_count)), 1);
            chk("rd_credit", 512'((m_rd - m_wr) < RD), 1);
            chk("rd_idx", o_lq_rd_idx, 512'((j_lqid + m_rd) % 8));
            if (i_lq_rd_ready) begin
                rsp_t r;
                r.d = rnd512();
                r.tag = serial;
                r.due = cyc + $urandom_range(lat_max, lat_min);
                pipe.push_back(r);
                rd_log.push_back(int'(o_lq_rd_idx));
                m_rd++;
            end
        end

        if (o_ldb_wr_valid) begin
            if (arrived.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_nodata actual=write_valid required=no_write_before_data_arrived");
            end else begin
                chk("wr_data", o_ldb_wr_data, arrived[0].d);
                chk("wr_no_bypass", 512'(arrived[0].arr < cyc), 1);
            end
            chk("wr_idx", o_ldb_wr_idx, 512'((j_ldb + m_wr) % 8));
            if (wr_hs) begin
                chk("free_idx", o_lq_free_idx, 512'((j_lqid + m_wr) % 8));
                chk("complete_idx", o_drain_complete_ldb_idx, 512'((j_ldb + m_wr) % 8));
                $display("wr job=%0d slot=%0d lq=%0d cyc=%0d", serial, o_ldb_wr_idx, o_lq_free_idx, cyc);
                if (arrived.size() != 0) void'(arrived.pop_front());
                wr_log.push_back(int'(o_ldb_wr_idx));
                m_wr++;
            end
        end

        if (i_lq_rsp_valid && cur_tag == serial && !i_flush) begin
            arr_t a;
            a.d = i_lq_rsp_data;
            a.arr = cyc;
            arrived.push_back(a);
        end

        if (i_flush) begin
            next_busy = 1'b0;
            arrived.delete();
            serial++;
        end else if (!exp_busy) begin
            next_busy = i_drain_req_valid;
            if (i_drain_req_valid) begin
                j_count = int'(i_drain_req_count);
                j_lqid  = int'(i_drain_req_lqid);
                j_ldb   = int'(i_drain_req_ldb);
                m_rd = 0;
                m_wr = 0;
                serial++;
                n_accept++;
                arrived.delete();
            end
        end else begin
            next_busy = !(j_count == 0 || m_wr == j_count);
        end

        prev_wr_stall = o_ldb_wr_valid && !i_ldb_wr_ready && !i_flush;
        prev_wr_idx   = o_ldb_wr_idx;
        prev_wr_data  = o_ldb_wr_data;
        prev_rd_stall = o_lq_rd_valid && !i_lq_rd_ready && !i_flush;
        prev_rd_idx   = o_lq_rd_idx;
        exp_busy      = next_busy;
    endfunction

    // Runs just after each posedge. Plays the part of the LQ and the LDB.
    function automatic void drive_env();
        i_lq_rsp_valid = 1'b0;
        i_lq_rsp_data  = '0;
        if (!reset_n) begin
            pipe.delete();
            return;
        end
        i_lq_rd_ready  = ($urandom_range(99, 0) < rd_pct);
        i_ldb_wr_ready = !wr_block && ($urandom_range(99, 0) < wr_pct);
        if (pipe.size() != 0 && pipe[0].due <= cyc) begin
            i_lq_rsp_valid = 1'b1;
            i_lq_rsp_data  = pipe[0].d;
            cur_tag        = pipe[0].tag;
            void'(pipe.pop_front());
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        drive_env();
    endtask

    task automatic do_reset(int n);
        reset_n = 1'b0;
        i_drain_req_valid = 1'b0;
        i_flush = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_job(int cnt, int lq, int ldb);
        i_drain_req_count = 4'(cnt);
        i_drain_req_lqid  = 3'(lq);
        i_drain_req_ldb   = 3'(ldb);
        i_drain_req_valid = 1'b1;
        tick();
        i_drain_req_valid = 1'b0;
    endtask

    task automatic wait_done(int bound, string name);
        int n = 0;
        while (exp_busy && n < bound) begin
            tick();
            n++;
        end
        if (exp_busy) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s actual=busy_after_%0d_cycles required=idle", name, bound);
            do_reset(2);
        end
        repeat (2) tick();
    endtask

    task automatic run_t1(string tag);
        int exp_rd[3] = '{6, 7, 0};
        int exp_wr[3] = '{7, 0, 1};
        rd_log.delete();
        wr_log.delete();
        rd_pct = 100; wr_pct = 100; lat_min = 1; lat_max = 1;
        start_job(3, 6, 7);
        wait_done(60, tag);
        chk({tag, "_nrd"}, rd_log.size(), 3);
        chk({tag, "_nwr"}, wr_log.size(), 3);
        for (int i = 0; i < 3 && i < rd_log.size(); i++) chk({tag, "_rd_idx"}, rd_log[i], exp_rd[i]);
        for (int i = 0; i < 3 && i < wr_log.size(); i++) chk({tag, "_wr_idx"}, wr_log[i], exp_wr[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, maxocc, low, na0, n;
        reset_n = 1'b0;
        i_drain_req_valid = 1'b0;
        i_drain_req_count = '0;
        i_drain_req_lqid = '0;
        i_drain_req_ldb = '0;
        i_lq_rd_ready = 1'b0;
        i_lq_rsp_valid = 1'b0;
        i_lq_rsp_data = '0;
        i_ldb_wr_ready = 1'b0;
        i_flush = 1'b0;
        do_reset(3);
        tick();

        // T1: wrapping indices, latency 1
        run_t1("t1");

        // T2: zero-count job
        rd_log.delete(); wr_log.delete();
        start_job(0, 3, 3);
        busy_n = o_draining ? 1 : 0;
        repeat (5) begin tick(); if (o_draining) busy_n++; end
        chk("t2_busy_cycles", busy_n, 1);
        chk("t2_no_rd_wr", rd_log.size() + wr_log.size(), 0);

        // T3: LDB back-pressure on an 8-entry job
        rd_log.delete(); wr_log.delete();
        lat_min = 1; lat_max = 2; wr_block = 1'b1;
        start_job(8, 5, 2);
        maxocc = 0;
        repeat (10) begin tick(); if (m_rd - m_wr > maxocc) maxocc = m_rd - m_wr; end
        wr_block = 1'b0;
        wait_done(200, "t3");
        chk("t3_max_in_flight", maxocc, 2);
        chk("t3_nwr", wr_log.size(), 8);

        // T4: flush with two reads in flight, then a new job that must skip their data
        lat_min = 8; lat_max = 8;
        start_job(4, 1, 3);
        n = 0;
        while (m_rd < 2 && n < 30) begin tick(); n++; end
        chk("t4_two_reads_before_flush", m_rd, 2);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        lat_min = 1; lat_max = 3;
        rd_log.delete(); wr_log.delete();
        start_job(1, 2, 5);
        wait_done(100, "t4");
        chk("t4_nwr", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("t4_wr_slot", wr_log[0], 5);
        if (rd_log.size() > 0) chk("t4_rd_idx", rd_log[0], 2);

        // T5: back-to-back jobs with the request held high
        lat_min = 1; lat_max = 1;
        na0 = n_accept;
        i_drain_req_count = 4'd2; i_drain_req_lqid = 3'd0; i_drain_req_ldb = 3'd0;
        i_drain_req_valid = 1'b1;
        tick();
        i_drain_req_count = 4'd3; i_drain_req_lqid = 3'd4; i_drain_req_ldb = 3'd4;
        low = 0; n = 0;
        while (n_accept < na0 + 2 && n < 100) begin
            tick();
            if (!o_draining) low++;
            n++;
        end
        i_drain_req_valid = 1'b0;
        chk("t5_accepts", n_accept - na0, 2);
        chk("t5_low_cycles", low, 1);
        wait_done(100, "t5");

        // T6: reset in the middle of a job, then T1 again
        lat_min = 3; lat_max = 3;
        start_job(8, 3, 3);
        repeat (6) tick();
        do_reset(2);
        run_t1("t6");

        // Randomized jobs with random back-pressure, latency and occasional flush
        for (int j = 0; j < 40; j++) begin
            rd_pct = $urandom_range(100, 40);
            wr_pct = $urandom_range(100, 30);
            lat_min = 1;
            lat_max = $urandom_range(6, 1);
            start_job($urandom_range(8, 0), $urandom_range(7, 0), $urandom_range(7, 0));
            if ($urandom_range(3, 0) == 0) begin
                repeat ($urandom_range(8, 0)) tick();
                i_flush = 1'b1;
                i_drain_req_valid = 1'($urandom_range(1, 0));
                tick();
                i_flush = 1'b0;
                i_drain_req_valid = 1'b0;
            end
            wait_done(400, "rand");
        end

        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
